imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Registered, parametrised immediate extender for the processor decode stage. It sign-extends the three immediate formats to `DATA_W` bits. It also adds a prefix mode: one instruction supplies the upper immediate bits, and the next immediate-bearing instruction supplies the lower bits. It sits between instruction fetch/decode and the register-read stage, with valid/ready handshakes on both sides and one cycle of latency.

## Interface
- `INSTR_W`, 28: width of the instruction field presented (opcode stripped).
- `DATA_W`, 32: extended immediate width; must be ≥ 20.
- `PREFIX_W`, 16: number of upper bits supplied by a prefix; 1 ≤ `PREFIX_W` ≤ `DATA_W`−1.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `instr`/`imm_src` valid.
- `in_ready` output 1: block accepts input this cycle.
- `instr` input `INSTR_W`: instruction bits.
- `imm_src` input 2: format select (`imm_src_e`).
- `flush` input 1: pipeline flush; drops held output and pending prefix.
- `out_valid` output 1: `ext_imm` valid.
- `out_ready` input 1: downstream accepts output.
- `ext_imm` output `DATA_W`: extended immediate.
- `out_prefixed` output 1: `ext_imm` upper bits came from a prefix.
- `pfx_pending` output 1: a prefix is held, waiting for its consumer.

## Operation
- Formats, where the field is sign-extended to `DATA_W`:
  - `IMM_20` (00): `instr[19:0]`.
  - `IMM_18` (01): `instr[17:0]`.
  - `IMM_BR` (10): `instr[16:0]`.
  - `IMM_PFX` (11): latch `instr[PREFIX_W-1:0]` into the prefix register; produces no output.
- Accept condition: `in_valid && in_ready`.
- Prefix FSM states:
  - `NO_PFX`: an accepted `IMM_PFX` stores the prefix and moves to `PFX_HELD`. An accepted non-prefix instruction loads the extended value and sets `out_prefixed`=0.
  - `PFX_HELD`: an accepted `IMM_PFX` overwrites the stored prefix and stays in `PFX_HELD` (last prefix wins). An accepted non-prefix instruction loads `ext_imm` = {prefix, extended_field[DATA_W-PREFIX_W-1:0]}, sets `out_prefixed`=1, and returns to `NO_PFX`.
- `pfx_pending` = (state == `PFX_HELD`).
- `flush`:
  - State goes to `NO_PFX` and `out_valid` goes to 0 on the next edge.
  - `in_ready`=0 in the flush cycle, so no input is accepted.
  - `flush` wins over all simultaneous events.
- Output register: one entry; holds `ext_imm`/`out_prefixed` stable while `out_valid && !out_ready`.
- Arithmetic: pure bit selection and replication; no adders.
- `X`/undefined values are never driven, for any `imm_src`.

## Timing
- Reset values:
  - state = `NO_PFX`, prefix = 0.
  - `out_valid`=0, `ext_imm`=0, `out_prefixed`=0, `pfx_pending`=0.
  - `in_ready` = 1 once `rst_n` is high and `flush`=0.
- `in_ready` = `!flush && (!out_valid || out_ready)`, combinational. This allows full throughput: one accept per cycle with `out_ready` held high.
- Latency: a non-prefix instruction accepted in cycle N gives `out_valid`=1 with its value in cycle N+1.
- A prefix accept does not set `out_valid`. If the output register is draining in the same cycle, `out_valid` falls at N+1.
- Handshake rules:
  - `out_valid` never drops without `out_ready` or `flush`.
  - `ext_imm` never changes while `out_valid && !out_ready`.
- Simultaneous output handshake and new accept in the same cycle: the output is replaced by the new value with no bubble.
- Reset asserted mid-operation (including in `PFX_HELD`): all state returns to reset values immediately (asynchronously). A pending prefix is lost.

## Structure
- Package `imm_pkg`:
  - `typedef enum logic [1:0] imm_src_e {IMM_20, IMM_18, IMM_BR, IMM_PFX}`.
  - Field-width constants 20/18/17.
  - Prefix FSM state enum `pfx_state_e {NO_PFX, PFX_HELD}`.
- Sub-module `imm_field_ext`: combinational, parametrised by `INSTR_W` and `DATA_W`; maps `instr` and `imm_src` to the sign-extended field. Returns 0 for `IMM_PFX`.
- Top level contains the FSM, the prefix register, the output register and the handshake logic.
- Elaboration-time assertions check the parameter constraints.

## Test plan
- Basic formats, defaults, `out_ready`=1:
  - `IMM_20`, `instr[19:0]`=0x80001 → `ext_imm`=0xFFF80001 one cycle later.
  - `IMM_18`, 0x20000 → 0xFFFE0000.
  - `IMM_BR`, 0x0FFFF → 0x0000FFFF.
- Prefix pair:
  - `IMM_PFX` 0xABCD, then `IMM_20` with `instr[19:0]`=0x01234 → one output 0xABCD1234, `out_prefixed`=1.
  - `pfx_pending` is high for exactly the cycle between the two accepts.
- Double prefix: `IMM_PFX` 0x1111, then `IMM_PFX` 0x2222, then `IMM_BR` 0x00005 → 0x22220005. No output is produced for either prefix.
- Backpressure:
  - `out_ready`=0 for 3 cycles after an output → `ext_imm` stable and `in_ready`=0.
  - On release: back-to-back accepts with no bubble.
- Flush and reset:
  - `flush` in `PFX_HELD` with a valid output held and `in_valid`=1 → next cycle `out_valid`=0, `pfx_pending`=0, input not accepted.
  - Next `IMM_20` 0x00010 → 0x00000010, `out_prefixed`=0.
  - Repeat with `rst_n` pulsed low instead of `flush`; same result.
- Random streams against a reference model with random `out_ready`: checks values, ordering and prefix pairing.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate extender.
// Immediate format selects, field widths and prefix FSM states.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_20  = 2'b00,
        IMM_18  = 2'b01,
        IMM_BR  = 2'b10,
        IMM_PFX = 2'b11
    } imm_src_e;

    localparam int IMM20_W = 20;
    localparam int IMM18_W = 18;
    localparam int IMMBR_W = 17;

    typedef enum logic {
        NO_PFX   = 1'b0,
        PFX_HELD = 1'b1
    } pfx_state_e;

endpackage

// File: rtl/imm_field_ext.sv
// Combinational sign extension of the selected immediate field.
// A prefix select carries no field of its own and yields zero.
module imm_field_ext
    import imm_pkg::*;
#(
    parameter int INSTR_W = 28,
    parameter int DATA_W  = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_src_e           imm_src,
    output logic [DATA_W-1:0]  field
);

    logic unused_instr;
    assign unused_instr = ^instr;

    // Pick the field and sign-extend through a signed size cast.
    always_comb begin
        field = '0;
        unique case (imm_src)
            IMM_20:  field = DATA_W'($signed(instr[IMM20_W-1:0]));
            IMM_18:  field = DATA_W'($signed(instr[IMM18_W-1:0]));
            IMM_BR:  field = DATA_W'($signed(instr[IMMBR_W-1:0]));
            IMM_PFX: field = '0;
            default: field = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with prefix pairing and
// valid/ready handshakes on both sides, one cycle of latency.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int INSTR_W  = 28,
    parameter int DATA_W   = 32,
    parameter int PREFIX_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [1:0]         imm_src,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  ext_imm,
    output logic               out_prefixed,
    output logic               pfx_pending
);

    if (DATA_W < 20) begin : g_bad_data_w
        $error("DATA_W must be at least 20");
    end
    if (INSTR_W < 20) begin : g_bad_instr_w
        $error("INSTR_W must be at least 20");
    end
    if (PREFIX_W < 1 || PREFIX_W > DATA_W - 1) begin : g_bad_pfx_w
        $error("PREFIX_W must be in 1..DATA_W-1");
    end
    if (PREFIX_W > INSTR_W) begin : g_bad_pfx_src
        $error("PREFIX_W must not exceed INSTR_W");
    end

    pfx_state_e          state_q, state_d;
    logic [PREFIX_W-1:0] pfx_q, pfx_d;
    logic                ov_q, ov_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                pref_q, pref_d;
    logic [DATA_W-1:0]   field;
    logic [DATA_W-1:0]   merged;
    imm_src_e            src;
    logic                accept;

    assign src         = imm_src_e'(imm_src);
    assign in_ready    = !flush && (!ov_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = ov_q;
    assign ext_imm     = imm_q;
    assign out_prefixed = pref_q;
    assign pfx_pending = (state_q == PFX_HELD);

    imm_field_ext #(
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W)
    ) u_field (
        .instr   (instr),
        .imm_src (src),
        .field   (field)
    );

    // Prefix supplies the upper bits, the field keeps the rest.
    always_comb begin
        merged = field;
        merged[DATA_W-1 -: PREFIX_W] = pfx_q;
    end

    // Next-state: flush first, then accepted prefix or immediate.
    always_comb begin
        state_d = state_q;
        pfx_d   = pfx_q;
        ov_d    = ov_q && !out_ready;
        imm_d   = imm_q;
        pref_d  = pref_q;
        if (flush) begin
            state_d = NO_PFX;
            pfx_d   = '0;
            ov_d    = 1'b0;
        end else if (accept) begin
            if (src == IMM_PFX) begin
                pfx_d   = instr[PREFIX_W-1:0];
                state_d = PFX_HELD;
            end else begin
                ov_d = 1'b1;
                unique case (state_q)
                    PFX_HELD: begin
                        imm_d  = merged;
                        pref_d = 1'b1;
                    end
                    default: begin
                        imm_d  = field;
                        pref_d = 1'b0;
                    end
                endcase
                state_d = NO_PFX;
            end
        end
    end

    // State, prefix and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NO_PFX;
            pfx_q   <= '0;
            ov_q    <= 1'b0;
            imm_q   <= '0;
            pref_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pfx_q   <= pfx_d;
            ov_q    <= ov_d;
            imm_q   <= imm_d;
            pref_q  <= pref_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and random-stream checks for imm_extend_pipe.
// Expected values are hand-computed or come from a small model.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] instr;
    logic [1:0]  imm_src;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_imm;
    logic        out_prefixed;
    logic        pfx_pending;

    int checks = 0;
    int errors = 0;

    imm_extend_pipe #(
        .INSTR_W  (28),
        .DATA_W   (32),
        .PREFIX_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .imm_src      (imm_src),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ext_imm      (ext_imm),
        .out_prefixed (out_prefixed),
        .pfx_pending  (pfx_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one input for one cycle; it must be accepted.
    task automatic send(input logic [1:0] s, input logic [27:0] v);
        in_valid = 1'b1;
        imm_src  = s;
        instr    = v;
        @(negedge clk);
        chk("send_rdy", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] sext(input logic [1:0] s,
                                         input logic [27:0] v);
        logic [31:0] r;
        case (s)
            2'b00:   r = {{12{v[19]}}, v[19:0]};
            2'b01:   r = {{14{v[17]}}, v[17:0]};
            2'b10:   r = {{15{v[16]}}, v[16:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic [31:0] exp_q[$];
    logic        expp_q[$];
    logic        m_held;
    logic [15:0] m_pfx;
    logic [31:0] e;
    logic        ep;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = 2'b00;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_ov",   {31'd0, out_valid},    32'd0);
        chk("rst_imm",  ext_imm,               32'd0);
        chk("rst_pref", {31'd0, out_prefixed}, 32'd0);
        chk("rst_pend", {31'd0, pfx_pending},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        step();

        // basic formats
        send(2'b00, 28'h0080001);
        chk("i20_ov",   {31'd0, out_valid}, 32'd1);
        chk("i20_val",  ext_imm, 32'hFFF80001);
        chk("i20_pref", {31'd0, out_prefixed}, 32'd0);
        send(2'b01, 28'h0020000);
        chk("i18_val",  ext_imm, 32'hFFFE0000);
        send(2'b10, 28'hFF0FFFF);
        chk("ibr_val",  ext_imm, 32'h0000FFFF);

        // prefix pair
        send(2'b11, 28'h000ABCD);
        chk("pp_ov",   {31'd0, out_valid},   32'd0);
        chk("pp_pend", {31'd0, pfx_pending}, 32'd1);
        send(2'b00, 28'h0001234);
        chk("pp_val",  ext_imm, 32'hABCD1234);
        chk("pp_pref", {31'd0, out_prefixed}, 32'd1);
        chk("pp_pend0", {31'd0, pfx_pending}, 32'd0);
        step();
        chk("pp_drain", {31'd0, out_valid}, 32'd0);

        // double prefix, last one wins
        send(2'b11, 28'h0001111);
        chk("dp_ov1", {31'd0, out_valid}, 32'd0);
        send(2'b11, 28'h0002222);
        chk("dp_ov2", {31'd0, out_valid}, 32'd0);
        send(2'b10, 28'h0000005);
        chk("dp_val",  ext_imm, 32'h22220005);
        chk("dp_pref", {31'd0, out_prefixed}, 32'd1);
        step();

        // backpressure and no-bubble release
        out_ready = 1'b0;
        send(2'b00, 28'h0000777);
        in_valid = 1'b1;
        imm_src  = 2'b01;
        instr    = 28'h003FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ov",  {31'd0, out_valid}, 32'd1);
            chk("bp_val", ext_imm, 32'h00000777);
            chk("bp_rdy", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_rdy", {31'd0, in_ready}, 32'd1);
        step();
        chk("rel_val1", ext_imm, 32'hFFFFFFFF);
        imm_src = 2'b10;
        instr   = 28'h0010000;
        step();
        chk("rel_ov2",  {31'd0, out_valid}, 32'd1);
        chk("rel_val2", ext_imm, 32'hFFFF0000);
        in_valid = 1'b0;
        step();
        chk("rel_idle", {31'd0, out_valid}, 32'd0);

        // flush with an output held
        out_ready = 1'b0;
        send(2'b00, 28'h0000042);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fh_ov", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // flush in PFX_HELD with input presented
        send(2'b11, 28'h0005555);
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        imm_src   = 2'b00;
        instr     = 28'h0000099;
        @(negedge clk);
        chk("fl_rdy", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_ov",   {31'd0, out_valid},   32'd0);
        chk("fl_pend", {31'd0, pfx_pending}, 32'd0);
        out_ready = 1'b1;
        send(2'b00, 28'h0000010);
        chk("fl_val",  ext_imm, 32'h00000010);
        chk("fl_pref", {31'd0, out_prefixed}, 32'd0);
        step();

        // asynchronous reset in PFX_HELD
        send(2'b11, 28'h000ABCD);
        rst_n = 1'b0;
        #1;
        chk("ar_pend", {31'd0, pfx_pending}, 32'd0);
        chk("ar_ov",   {31'd0, out_valid},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(2'b00, 28'h0000010);
        chk("ar_val",  ext_imm, 32'h00000010);
        chk("ar_pref", {31'd0, out_prefixed}, 32'd0);
        step();

        // random stream against a model
        m_held = 1'b0;
        m_pfx  = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            imm_src   = 2'($urandom_range(0, 3));
            instr     = 28'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            chk("rs_pend", {31'd0, pfx_pending}, {31'd0, m_held});
            if (out_valid && exp_q.size() == 0)
                chk("rs_spur", 32'd1, 32'd0);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ep = expp_q.pop_front();
                chk("rs_val",  ext_imm, e);
                chk("rs_pref", {31'd0, out_prefixed}, {31'd0, ep});
            end
            if (in_valid && in_ready) begin
                if (imm_src == 2'b11) begin
                    m_pfx  = instr[15:0];
                    m_held = 1'b1;
                end else begin
                    e = sext(imm_src, instr);
                    if (m_held)
                        e = {m_pfx, e[15:0]};
                    exp_q.push_back(e);
                    expp_q.push_back(m_held);
                    m_held = 1'b0;
                end
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        if (out_valid && exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            ep = expp_q.pop_front();
            chk("rs_last", ext_imm, e);
            chk("rs_lastp", {31'd0, out_prefixed}, {31'd0, ep});
        end
        step();
        chk("rs_empty", exp_q.size(), 32'd0);
        chk("rs_end_ov", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
